// File: rtl/gray_ptr_sync_decode.sv
// Synchronises a free-running Gray count into clk, decodes it to binary and reports each advance as a step/delta pulse plus a saturating total.
// Optional multi-bit Gray transition detection (sticky err) is enabled by defining GRAY_MULTI_STEP_ERR_EN.
module gray_ptr_sync_decode #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACC_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     gray_in,
  input  logic             clr,
  output logic [W-1:0]     bin_out,
  output logic             step,
  output logic [W-1:0]     delta,
  output logic [ACC_W-1:0] total,
  output logic             locked,
  output logic             err
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
`ifdef GRAY_MULTI_STEP_ERR_EN
  localparam logic [1:0] ST_ERR   = 2'd2;
`endif

  localparam int CW = (SYNC_STAGES < 2) ? 2 : $clog2(SYNC_STAGES + 1);
  localparam int SW = ((ACC_W > W) ? ACC_W : W) + 1;
  localparam logic [ACC_W-1:0] TOTAL_MAX = '1;

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]     gray_s;
  logic [W-1:0]     bin_cur;
  logic [W-1:0]     bin_q, bin_d;
  logic [W-1:0]     delta_q, delta_d;
  logic             step_q, step_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic             locked_q, locked_d;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     delta_calc;
  logic [SW-1:0]    sum;
  logic [ACC_W-1:0] total_sat;
`ifdef GRAY_MULTI_STEP_ERR_EN
  logic [W-1:0]     gray_q, gray_d;
  logic [W-1:0]     gray_diff;
  logic             multi_bit;
  logic             err_q, err_d;
`endif

  // Plain flop chain: nothing may sit between stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gray_in};
  end

  assign gray_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    bin_cur = '0;
    for (int i = 0; i < W; i++) begin
      bin_cur[i] = ^(gray_s >> i);
    end
  end

  assign bin_d      = bin_cur;
  assign delta_calc = bin_cur - bin_q;
  assign sum        = SW'(total_q) + SW'(delta_calc);
  assign total_sat  = (sum > SW'(TOTAL_MAX)) ? TOTAL_MAX : sum[ACC_W-1:0];

`ifdef GRAY_MULTI_STEP_ERR_EN
  assign gray_d    = gray_s;
  assign gray_diff = gray_s ^ gray_q;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_bit = |(gray_diff & (gray_diff - W'(1)));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    delta_d  = '0;
    total_d  = total_q;
    locked_d = locked_q;
`ifdef GRAY_MULTI_STEP_ERR_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_INIT: begin
        // bin_q follows the input during settle, so the value at lock is the baseline.
        if (cnt_q == CW'(SYNC_STAGES)) begin
          state_d  = ST_TRACK;
          locked_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TRACK: begin
`ifdef GRAY_MULTI_STEP_ERR_EN
        if (multi_bit) begin
          state_d  = ST_ERR;
          err_d    = 1'b1;
          locked_d = 1'b0;
        end else
`endif
        if (bin_cur != bin_q) begin
          step_d  = 1'b1;
          delta_d = delta_calc;
          total_d = total_sat;
        end
      end
`ifdef GRAY_MULTI_STEP_ERR_EN
      ST_ERR: begin
        locked_d = 1'b0;
      end
`endif
      default: begin
        state_d  = ST_INIT;
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    endcase

    if (clr) begin
      state_d  = ST_INIT;
      cnt_d    = '0;
      total_d  = '0;
      step_d   = 1'b0;
      delta_d  = '0;
      locked_d = 1'b0;
`ifdef GRAY_MULTI_STEP_ERR_EN
      err_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      bin_q    <= '0;
      delta_q  <= '0;
      step_q   <= 1'b0;
      total_q  <= '0;
      locked_q <= 1'b0;
      state_q  <= ST_INIT;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      bin_q    <= bin_d;
      delta_q  <= delta_d;
      step_q   <= step_d;
      total_q  <= total_d;
      locked_q <= locked_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef GRAY_MULTI_STEP_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
      err_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bin_out = bin_q;
  assign step    = step_q;
  assign delta   = delta_q;
  assign total   = total_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_gray_ptr_sync_decode.sv
// Directed bench for gray_ptr_sync_decode: a vector table for single advances plus sequences for
// multi-bit jumps, clr, saturation (second instance with ACC_W=4) and asynchronous reset.
module tb_gray_ptr_sync_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  gray_in = 4'd0;

  logic [3:0]  bin_out, delta;
  logic        step, locked, err;
  logic [15:0] total;

  logic [3:0]  s_bin_out, s_delta;
  logic        s_step, s_locked, s_err;
  logic [3:0]  s_total;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] gray;
    logic [3:0] bin;
    int         steps;
    logic [3:0] dlt;
    int         tot;
  } vec_t;

  vec_t vecs[12];

  gray_ptr_sync_decode #(.W(4), .SYNC_STAGES(2), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr),
    .bin_out(bin_out), .step(step), .delta(delta), .total(total),
    .locked(locked), .err(err)
  );

  gray_ptr_sync_decode #(.W(4), .SYNC_STAGES(2), .ACC_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr),
    .bin_out(s_bin_out), .step(s_step), .delta(s_delta), .total(s_total),
    .locked(s_locked), .err(s_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Samples n cycles on the falling edge; index 0 is the first edge after the caller's drive.
  task automatic watch(input int n, output int steps, output int first, output logic [3:0] dlt);
    steps = 0;
    first = -1;
    dlt   = 4'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step) begin
        if (first < 0) first = i;
        steps++;
        dlt = delta;
      end
    end
  endtask

  initial begin
    int         steps, first, run, maxrun, bad, s_steps;
    logic [3:0] dlt, b;

    vecs[0]  = '{4'b0001, 4'd1,  1, 4'd1,  1};
    vecs[1]  = '{4'b0011, 4'd2,  1, 4'd1,  2};
    vecs[2]  = '{4'b0010, 4'd3,  1, 4'd1,  3};
    vecs[3]  = '{4'b0110, 4'd4,  1, 4'd1,  4};
    vecs[4]  = '{4'b0111, 4'd5,  1, 4'd1,  5};
    vecs[5]  = '{4'b0101, 4'd6,  1, 4'd1,  6};
    vecs[6]  = '{4'b0100, 4'd7,  1, 4'd1,  7};
    vecs[7]  = '{4'b1100, 4'd8,  1, 4'd1,  8};
    vecs[8]  = '{4'b1000, 4'd15, 1, 4'd7,  15};
    vecs[9]  = '{4'b0000, 4'd0,  1, 4'd1,  16};
    vecs[10] = '{4'b0001, 4'd1,  1, 4'd1,  17};
    vecs[11] = '{4'b0000, 4'd0,  1, 4'd15, 32};

    // Reset state and lock sequence.
    #2;
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_total", 32'(total), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); chk("lock_e1", 32'(locked), 0);
    @(negedge clk); chk("lock_e2", 32'(locked), 0);
    @(negedge clk); chk("lock_e3", 32'(locked), 1);
    chk("lock_bin", 32'(bin_out), 0);
    chk("lock_total", 32'(total), 0);
    chk("lock_step", 32'(step), 0);

    // Single advances, wrap-around and a backward move.
    for (int v = 0; v < 12; v++) begin
      gray_in = vecs[v].gray;
      watch(4, steps, first, dlt);
      chk($sformatf("v%0d_bin", v), 32'(bin_out), 32'(vecs[v].bin));
      chk($sformatf("v%0d_steps", v), 32'(steps), 32'(vecs[v].steps));
      chk($sformatf("v%0d_lat", v), 32'(first), 2);
      chk($sformatf("v%0d_delta", v), 32'(dlt), 32'(vecs[v].dlt));
      chk($sformatf("v%0d_total", v), 32'(total), 32'(vecs[v].tot));
      chk($sformatf("v%0d_locked", v), 32'(locked), 1);
    end

    // Two-bit Gray jump 0000 -> 0011 (binary 0 -> 2).
    gray_in = 4'b0011;
    watch(4, steps, first, dlt);
    chk("jump_bin", 32'(bin_out), 2);
`ifdef GRAY_MULTI_STEP_ERR_EN
    chk("jump_steps", 32'(steps), 0);
    chk("jump_err", 32'(err), 1);
    chk("jump_locked", 32'(locked), 0);
    chk("jump_total", 32'(total), 32);
`else
    chk("jump_steps", 32'(steps), 1);
    chk("jump_delta", 32'(dlt), 2);
    chk("jump_err", 32'(err), 0);
    chk("jump_total", 32'(total), 34);
`endif
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_err", 32'(err), 0);
    chk("clr_locked", 32'(locked), 0);
    chk("clr_total", 32'(total), 0);
    @(negedge clk); chk("clr_lock_e1", 32'(locked), 0);
    @(negedge clk); chk("clr_lock_e2", 32'(locked), 0);
    @(negedge clk); chk("clr_lock_e3", 32'(locked), 1);
    chk("clr_bin", 32'(bin_out), 2);

    // 20 back-to-back increments; ACC_W=4 instance must saturate at 15.
    b = 4'd2;
    steps = 0; run = 0; maxrun = 0; bad = 0; s_steps = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < 20) begin
        b = b + 4'd1;
        gray_in = b ^ (b >> 1);
      end
      @(negedge clk);
      if (step) begin
        steps++;
        run++;
        if (delta != 4'd1) bad++;
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      if (s_step) s_steps++;
    end
    chk("b2b_steps", 32'(steps), 20);
    chk("b2b_run", 32'(maxrun), 20);
    chk("b2b_bad_delta", 32'(bad), 0);
    chk("b2b_total", 32'(total), 20);
    chk("b2b_bin", 32'(bin_out), 6);
    chk("sat_steps", 32'(s_steps), 20);
    chk("sat_total", 32'(s_total), 15);

    // Build total=7, bin_out=9, then assert reset between clock edges.
    clr = 1'b1;
    gray_in = 4'b0011;
    @(negedge clk);
    clr = 1'b0;
    watch(5, steps, first, dlt);
    chk("pre_locked", 32'(locked), 1);
    chk("pre_bin", 32'(bin_out), 2);
    chk("pre_steps", 32'(steps), 0);
    b = 4'd2;
    for (int i = 0; i < 7; i++) begin
      b = b + 4'd1;
      gray_in = b ^ (b >> 1);
      @(negedge clk);
    end
    watch(4, steps, first, dlt);
    chk("pre_total7", 32'(total), 7);
    chk("pre_bin9", 32'(bin_out), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bin", 32'(bin_out), 0);
    chk("arst_total", 32'(total), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_step", 32'(step), 0);
    chk("arst_delta", 32'(delta), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); chk("relock_e1", 32'(locked), 0);
    @(negedge clk); chk("relock_e2", 32'(locked), 0);
    @(negedge clk); chk("relock_e3", 32'(locked), 1);
    watch(3, steps, first, dlt);
    chk("relock_bin", 32'(bin_out), 9);
    chk("relock_steps", 32'(steps), 0);
    chk("relock_total", 32'(total), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
